// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit and its direct-mapped cache array.
package inst_fetch_unit_pkg;

    localparam int unsigned ICACHE_INDEX_WIDTH = 6;
    localparam int unsigned ICACHE_TAG_WIDTH   = 30 - ICACHE_INDEX_WIDTH;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational lookup, single write port.
module icache_array
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int unsigned TAG_WIDTH   = ICACHE_TAG_WIDTH
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    input  logic [TAG_WIDTH-1:0]   rd_tag,
    output logic                   hit,
    output logic [31:0]            rd_data,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [31:0]            wr_data
);

    localparam int unsigned LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]     valid_q;
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [31:0]          data_q [LINES];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data contents are only meaningful behind a set valid bit.
    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/inst_fetch_unit.sv
// Decoder-facing instruction fetch: cache lookup on request, 4-byte refill over the arbiter port.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int unsigned TAG_WIDTH   = 30 - INDEX_WIDTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        mc_en,
    input  logic [31:0] mc_addr,
    output logic        mc_rdy,
    output logic [31:0] mc_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din
);

    logic [1:0]  state_q, state_d;
    logic [2:0]  issued_q, issued_d;
    logic [2:0]  recv_q, recv_d;
    logic        pend_q, pend_d;
    logic [31:0] base_q, base_d;
    logic [31:0] asm_q, asm_d;
    logic        mc_rdy_q, mc_rdy_d;
    logic [31:0] mc_data_q, mc_data_d;
    logic        hit;
    logic [31:0] hit_data;
    logic        fill_we;
    logic        grant;

    icache_array #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_array (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rd_idx (mc_addr[INDEX_WIDTH+1:2]),
        .rd_tag (mc_addr[31:INDEX_WIDTH+2]),
        .hit    (hit),
        .rd_data(hit_data),
        .we     (fill_we),
        .wr_idx (base_q[INDEX_WIDTH+1:2]),
        .wr_tag (base_q[31:INDEX_WIDTH+2]),
        .wr_data(asm_d)
    );

    assign mem_req  = (state_q == REFILL) && (issued_q < 3'd4) && rdy_in;
    assign mem_addr = base_q + {29'd0, issued_q};
    assign grant    = mem_req && mem_gnt;
    assign mc_rdy   = mc_rdy_q;
    assign mc_data  = mc_data_q;

    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        recv_d    = recv_q;
        base_d    = base_q;
        asm_d     = asm_q;
        mc_rdy_d  = mc_rdy_q;
        mc_data_d = mc_data_q;
        fill_we   = 1'b0;
        pend_d    = grant;

        // Receive path ignores rdy_in so a byte granted just before a stall is not lost.
        if ((state_q == REFILL) && pend_q) begin
            asm_d[{recv_q[1:0], 3'b000} +: 8] = mem_din;
            recv_d = recv_q + 3'd1;
        end

        if (rdy_in) begin
            mc_rdy_d = 1'b0;
            if (flush) begin
                state_d  = IDLE;
                issued_d = 3'd0;
                recv_d   = 3'd0;
                pend_d   = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (mc_en) begin
                            if (hit) begin
                                mc_data_d = hit_data;
                                mc_rdy_d  = 1'b1;
                                state_d   = RESP;
                            end else begin
                                base_d   = word_align(mc_addr);
                                issued_d = 3'd0;
                                recv_d   = 3'd0;
                                pend_d   = 1'b0;
                                state_d  = REFILL;
                            end
                        end
                    end
                    REFILL: begin
                        if (grant) begin
                            issued_d = issued_q + 3'd1;
                        end
                        // Lane 3 may have landed during a stall; complete once enabled.
                        if (recv_d == 3'd4) begin
                            fill_we   = 1'b1;
                            mc_data_d = asm_d;
                            mc_rdy_d  = 1'b1;
                            state_d   = RESP;
                        end
                    end
                    RESP: begin
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            issued_q  <= 3'd0;
            recv_q    <= 3'd0;
            pend_q    <= 1'b0;
            base_q    <= 32'd0;
            asm_q     <= 32'd0;
            mc_rdy_q  <= 1'b0;
            mc_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            recv_q    <= recv_d;
            pend_q    <= pend_d;
            base_q    <= base_d;
            asm_q     <= asm_d;
            mc_rdy_q  <= mc_rdy_d;
            mc_data_q <= mc_data_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed fetches against a small byte-RAM arbiter model.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        rdy_in;
    logic        flush;
    logic        mc_en;
    logic [31:0] mc_addr;
    logic        mc_rdy;
    logic [31:0] mc_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_din;

    inst_fetch_unit dut (
        .clk_in  (clk),
        .rst_in  (rst_n),
        .rdy_in  (rdy_in),
        .flush   (flush),
        .mc_en   (mc_en),
        .mc_addr (mc_addr),
        .mc_rdy  (mc_rdy),
        .mc_data (mc_data),
        .mem_req (mem_req),
        .mem_addr(mem_addr),
        .mem_gnt (mem_gnt),
        .mem_din (mem_din)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] glog[$];
    logic [7:0]  ram [512];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int c0 = 0;
    int gnt_mode = 0;   // 0: always grant, 1: grant on odd cycles after sample
    int req_cnt = 0;
    int stall_req = 0;
    int rdy_pulses = 0;
    logic        g_pend;
    logic [31:0] g_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_grants(input string name, input logic [31:0] base);
        check({name, "_count"}, 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check(name, (i < glog.size()) ? glog[i] : 32'hFFFF_FFFF, base + 32'(i));
        end
    endtask

    // Arbiter model: grant policy plus a byte returned one cycle after each grant.
    initial begin
        mem_gnt = 1'b0;
        mem_din = 8'h00;
        g_pend  = 1'b0;
        g_addr  = 32'd0;
        forever begin
            @(negedge clk);
            mem_din = g_pend ? ram[g_addr[8:0]] : 8'hEE;
            if (gnt_mode == 0) mem_gnt = 1'b1;
            else mem_gnt = (((cyc + 1 - c0) & 1) == 1);
            #1;
            g_pend = mem_req && mem_gnt;
            g_addr = mem_addr;
            if (g_pend) glog.push_back(mem_addr);
            if (mem_req) req_cnt++;
            if (!rdy_in && mem_req) stall_req++;
        end
    end

    // Monitor: every response pulse is matched against the oldest expectation.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (mc_rdy) begin
            rdy_pulses++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL response: unexpected pulse with data %h at cycle %0d, expected none",
                         mc_data, cyc);
            end else begin
                e = sb.pop_front();
                if (mc_data !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL response: got %h at cycle %0d, expected %h at cycle %0d",
                             mc_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    // lat counts cycles after the sampling edge, so the pulse is seen at edge c0 + lat - 1.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data, input int lat,
                         input int mode);
        exp_t e;
        int   waited;
        @(negedge clk);
        gnt_mode = mode;
        c0       = cyc + 2;
        glog.delete();
        req_cnt  = 0;
        @(negedge clk);
        mc_en   = 1'b1;
        mc_addr = addr;
        e.data  = exp_data;
        e.cyc   = c0 + lat - 1;
        sb.push_back(e);
        waited = 0;
        while (!mc_rdy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        mc_en = 1'b0;
        if (!mc_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_timeout: no response for %h, expected %h", addr, exp_data);
            sb.delete();
        end
    endtask

    initial begin
        int pulses0;
        rst_n   = 1'b0;
        rdy_in  = 1'b1;
        flush   = 1'b0;
        mc_en   = 1'b0;
        mc_addr = 32'd0;
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        {ram[3], ram[2], ram[1], ram[0]}             = 32'h0000_0513;
        {ram[259], ram[258], ram[257], ram[256]}     = 32'h0010_0093;
        {ram[67], ram[66], ram[65], ram[64]}         = 32'hAB34_1237;
        {ram[131], ram[130], ram[129], ram[128]}     = 32'hDEAD_BEEF;
        {ram[195], ram[194], ram[193], ram[192]}     = 32'h0403_0201;
        {ram[323], ram[322], ram[321], ram[320]}     = 32'h1234_5678;

        repeat (2) @(negedge clk);
        check("reset_mc_rdy", {31'd0, mc_rdy}, 32'd0);
        check("reset_mc_data", mc_data, 32'd0);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        // Cold miss then hit.
        fetch(32'h0000_0000, 32'h0000_0513, 6, 0);
        check_grants("cold_miss_addr", 32'h0000_0000);
        fetch(32'h0000_0002, 32'h0000_0513, 1, 0);
        check("hit_no_mem_req", 32'(req_cnt), 32'd0);

        // Same-index conflict evicts line 0.
        fetch(32'h0000_0100, 32'h0010_0093, 6, 0);
        check_grants("conflict_miss_addr", 32'h0000_0100);
        fetch(32'h0000_0000, 32'h0000_0513, 6, 0);
        check_grants("conflict_refetch_addr", 32'h0000_0000);

        // Alternating grants: three cycles slower.
        fetch(32'h0000_0040, 32'hAB34_1237, 9, 1);
        check_grants("alt_gnt_addr", 32'h0000_0040);

        // Flush one cycle after the second grant.
        @(negedge clk);
        gnt_mode = 0;
        @(negedge clk);
        pulses0 = rdy_pulses;
        mc_en   = 1'b1;
        mc_addr = 32'h0000_0080;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        mc_en = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_no_rdy", 32'(rdy_pulses), 32'(pulses0));
        check("flush_mem_req_idle", {31'd0, mem_req}, 32'd0);
        fetch(32'h0000_0080, 32'hDEAD_BEEF, 6, 0);
        check_grants("after_flush_addr", 32'h0000_0080);

        // rdy_in low for three cycles right after the first grant.
        stall_req = 0;
        fork
            fetch(32'h0000_00C0, 32'h0403_0201, 9, 0);
            begin
                repeat (4) @(negedge clk);
                rdy_in = 1'b0;
                repeat (3) @(negedge clk);
                rdy_in = 1'b1;
            end
        join
        check("stall_mem_req", 32'(stall_req), 32'd0);
        check_grants("stall_addr", 32'h0000_00C0);

        // Asynchronous reset in the middle of a refill.
        @(negedge clk);
        @(negedge clk);
        mc_en   = 1'b1;
        mc_addr = 32'h0000_0140;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_mc_rdy", {31'd0, mc_rdy}, 32'd0);
        check("async_rst_mc_data", mc_data, 32'd0);
        check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("async_rst_mem_addr", mem_addr, 32'd0);
        mc_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(32'h0000_0140, 32'h1234_5678, 6, 0);
        check_grants("post_rst_addr", 32'h0000_0140);
        fetch(32'h0000_0000, 32'h0000_0513, 6, 0);
        check_grants("post_rst_invalid_addr", 32'h0000_0000);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
